// File: rtl/main_mem_pkg.sv
// Shared types, default geometry and address helpers for the main-memory responder.
package main_mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT     = 2'd1,
    RD_BURST = 2'd2,
    WR_ACK   = 2'd3
  } state_t;

  // Counter width able to hold values up to n-1 (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Word address of the first word in the line containing addr.
  function automatic int unsigned line_base(input int unsigned addr, input int unsigned off_w);
    return (addr >> off_w) << off_w;
  endfunction

  // Word offset of addr within its line.
  function automatic int unsigned line_off(input int unsigned addr, input int unsigned off_w);
    return addr & ((32'd1 << off_w) - 32'd1);
  endfunction

  localparam int unsigned DEF_LINE_WORDS = 4;
  localparam int unsigned DEF_LATENCY    = 3;
  localparam int unsigned OFF_W          = $clog2(DEF_LINE_WORDS);
  localparam int unsigned LAT_W          = cnt_width(DEF_LATENCY);

endpackage

// File: rtl/main_mem_array.sv
// Backing storage: synchronous write, asynchronous read, contents survive reset.
module main_mem_array #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // Word write on the clock edge.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/main_mem_responder.sv
// Fixed-latency main-memory model serving line refills and write-through words.
// Build option: define MAIN_MEM_CWF_EN for critical-word-first refill order.
module main_mem_responder
  import main_mem_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned LATENCY    = DEF_LATENCY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_we,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [WIDTH-1:0]              req_wdata,
  output logic                          rsp_valid,
  output logic [WIDTH-1:0]              rsp_data,
  output logic [$clog2(LINE_WORDS)-1:0] rsp_beat,
  output logic                          rsp_last,
  output logic                          wr_done,
  output logic                          busy
);

  localparam int unsigned OFF_BITS = $clog2(LINE_WORDS);
  localparam int unsigned CNT_BITS = cnt_width(LATENCY);

  state_t                state;
  logic [CNT_BITS-1:0]   lat_cnt;
  logic [OFF_BITS-1:0]   beat_cnt;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [WIDTH-1:0]      wdata_q;

  logic [ADDR_WIDTH-1:0] src_addr_c;
  logic [OFF_BITS-1:0]   start_off_c;
  logic [OFF_BITS-1:0]   nxt_off_c;
  logic [ADDR_WIDTH-1:0] rd_addr_c;
  logic                  start_rsp_c;
  logic                  start_we_c;
  logic                  mem_we_c;
  logic [WIDTH-1:0]      rd_data_c;

  // Write lands on the edge closing WR_ACK unless reset hits that same edge.
  assign mem_we_c = (state == WR_ACK) && !rst;
  assign busy     = ~req_ready;

  main_mem_array #(
    .WIDTH      (WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (mem_we_c),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (rd_addr_c),
    .rdata (rd_data_c)
  );

  // Address of the beat to present next, and when the response phase begins.
  always_comb begin
    src_addr_c = (state == IDLE) ? req_addr : addr_q;
`ifdef MAIN_MEM_CWF_EN
    start_off_c = OFF_BITS'(line_off(32'(src_addr_c), OFF_BITS));
`else
    start_off_c = '0;
`endif
    nxt_off_c   = (state == RD_BURST) ? OFF_BITS'(rsp_beat + OFF_BITS'(1)) : start_off_c;
    rd_addr_c   = ADDR_WIDTH'(line_base(32'(src_addr_c), OFF_BITS) | 32'(nxt_off_c));
    start_rsp_c = ((state == IDLE) && req_valid && (LATENCY == 1)) ||
                  ((state == WAIT) && (lat_cnt == CNT_BITS'(1)));
    start_we_c  = (state == IDLE) ? req_we : we_q;
  end

  // Request capture, latency countdown, burst sequencing and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_beat  <= '0;
      rsp_last  <= 1'b0;
      wr_done   <= 1'b0;
      lat_cnt   <= '0;
      beat_cnt  <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q      <= req_we;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (LATENCY > 1) begin
              lat_cnt <= CNT_BITS'(LATENCY - 1);
              state   <= WAIT;
            end
          end
        end
        WAIT: begin
          lat_cnt <= lat_cnt - CNT_BITS'(1);
        end
        RD_BURST: begin
          if (beat_cnt == OFF_BITS'(LINE_WORDS - 1)) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_beat  <= '0;
            rsp_last  <= 1'b0;
            beat_cnt  <= '0;
          end else begin
            beat_cnt <= beat_cnt + OFF_BITS'(1);
            rsp_data <= rd_data_c;
            rsp_beat <= nxt_off_c;
            rsp_last <= (beat_cnt == OFF_BITS'(LINE_WORDS - 2));
          end
        end
        WR_ACK: begin
          state     <= IDLE;
          wr_done   <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
        end
      endcase

      // Entry into the response phase, shared by the WAIT exit and the single-cycle latency path.
      if (start_rsp_c) begin
        if (start_we_c) begin
          state   <= WR_ACK;
          wr_done <= 1'b1;
        end else begin
          state     <= RD_BURST;
          rsp_valid <= 1'b1;
          rsp_data  <= rd_data_c;
          rsp_beat  <= nxt_off_c;
          rsp_last  <= 1'b0;
          beat_cnt  <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Randomized scoreboard bench for main_mem_responder (honours MAIN_MEM_CWF_EN).
module tb_main_mem_responder;

  localparam int unsigned W   = 32;
  localparam int unsigned AW  = 10;
  localparam int unsigned LW  = 4;
  localparam int unsigned LAT = 3;

  typedef struct {
    int          cyc;
    bit          wr;
    logic [31:0] data;
    int          beat;
    bit          last;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_wdata;
  logic          rsp_valid;
  logic [W-1:0]  rsp_data;
  logic [1:0]    rsp_beat;
  logic          rsp_last;
  logic          wr_done;
  logic          busy;

  int   cyc     = 0;
  int   free_at = 0;
  int   checks  = 0;
  int   errors  = 0;
  int   last_t  = 0;
  int   w_ack   = -1;
  int   w_addr  = 0;
  logic [31:0] w_old;
  logic [31:0] mm [1024];
  exp_t q [$];

  main_mem_responder #(
    .WIDTH      (W),
    .ADDR_WIDTH (AW),
    .LINE_WORDS (LW),
    .LATENCY    (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_beat  (rsp_beat),
    .rsp_last  (rsp_last),
    .wr_done   (wr_done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: sample after each rising edge and compare against the scoreboard.
  always begin : monitor
    exp_t e;
    bit   ready_exp;
    @(posedge clk);
    #1;
    ready_exp = (cyc >= free_at);
    checks++;
    if (req_ready !== ready_exp) begin
      errors++;
      $display("FAIL req_ready cyc=%0d got=%b exp=%b", cyc, req_ready, ready_exp);
    end
    checks++;
    if (busy !== ~req_ready) begin
      errors++;
      $display("FAIL busy cyc=%0d got=%b req_ready=%b", cyc, busy, req_ready);
    end
    if (rsp_valid !== 1'b1) begin
      checks++;
      if (rsp_valid !== 1'b0 || rsp_data !== '0 || rsp_beat !== '0 || rsp_last !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs cyc=%0d got valid=%b data=%h beat=%0d last=%b exp all zero",
                 cyc, rsp_valid, rsp_data, rsp_beat, rsp_last);
      end
    end
    if (rsp_valid === 1'b1 || wr_done === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_rsp cyc=%0d got valid=%b wr_done=%b exp none", cyc, rsp_valid, wr_done);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || (rsp_valid === 1'b1 && wr_done === 1'b1) ||
            (e.wr && wr_done !== 1'b1) ||
            (!e.wr && (rsp_data !== e.data || int'(rsp_beat) != e.beat || rsp_last !== e.last))) begin
          errors++;
          $display("FAIL response got cyc=%0d wr=%b data=%h beat=%0d last=%b exp cyc=%0d wr=%b data=%h beat=%0d last=%b",
                   cyc, wr_done, rsp_data, rsp_beat, rsp_last, e.cyc, e.wr, e.data, e.beat, e.last);
        end
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      checks++;
      errors++;
      e = q.pop_front();
      $display("FAIL missing_rsp cyc=%0d got none exp wr=%b data=%h at cyc=%0d", cyc, e.wr, e.data, e.cyc);
    end
  end

  // Issue one request; holds req_valid until the model says the responder is free.
  task automatic accept(input bit we, input logic [AW-1:0] a, input logic [W-1:0] d);
    int base;
    int off0;
    int idx;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (cyc < free_at) @(negedge clk);
    last_t = cyc;
    if (we) begin
      w_addr = int'(a);
      w_old  = mm[a];
      w_ack  = last_t + LAT;
      mm[a]  = d;
      q.push_back('{last_t + LAT, 1'b1, 32'h0, 0, 1'b0});
      free_at = last_t + LAT + 1;
    end else begin
      base = int'(a) - (int'(a) % LW);
`ifdef MAIN_MEM_CWF_EN
      off0 = int'(a) % LW;
`else
      off0 = 0;
`endif
      for (int k = 0; k < LW; k++) begin
        idx = (off0 + k) % LW;
        q.push_back('{last_t + LAT + k, 1'b0, mm[base + idx], idx, (k == LW - 1)});
      end
      free_at = last_t + LAT + LW;
    end
    @(negedge clk);
  endtask

  // While busy, wiggle the request inputs (they must be ignored), then drop req_valid.
  task automatic idle_busy();
    while (cyc < free_at - 1) begin
      req_valid = 1'($urandom_range(0, 1));
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = AW'($urandom);
      req_wdata = $urandom;
      @(negedge clk);
    end
    req_valid = 1'b0;
  endtask

  // Pulse reset for the edge closing cycle n; outstanding work is discarded.
  task automatic reset_at(input int n);
    while (cyc < n) @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    if (w_ack >= cyc) mm[w_addr] = w_old;
    w_ack   = -1;
    free_at = cyc + 1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_op(input bit we, input logic [AW-1:0] a, input logic [W-1:0] d);
    accept(we, a, d);
    idle_busy();
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog cyc=%0d queue=%0d", cyc, q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [AW-1:0] a;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Fill the two address windows the random phase uses.
    for (int i = 0; i < 32; i++) do_op(1'b1, AW'(i), $urandom);
    for (int i = 0; i < 32; i++) do_op(1'b1, AW'(10'h3E0 + i), $urandom);

    // Single write timing.
    do_op(1'b1, 10'h005, 32'hDEADBEEF);

    // Line write then mid-line read.
    do_op(1'b1, 10'h004, 32'h11);
    do_op(1'b1, 10'h005, 32'h22);
    do_op(1'b1, 10'h006, 32'h33);
    do_op(1'b1, 10'h007, 32'h44);
    do_op(1'b0, 10'h006, '0);

    // Write held through a read burst, accepted only once idle.
    accept(1'b0, 10'h004, '0);
    accept(1'b1, 10'h3FF, 32'hCAFEF00D);
    idle_busy();
    do_op(1'b0, 10'h3FC, '0);

    // Reset during beat 1 of a read, then re-read.
    accept(1'b0, 10'h004, '0);
    req_valid = 1'b0;
    reset_at(last_t + LAT + 1);
    do_op(1'b0, 10'h004, '0);

    // Top-of-memory line: no wrap past 0x3FF.
    do_op(1'b1, 10'h3FF, $urandom);
    do_op(1'b0, 10'h3FE, '0);

    // Write dropped by reset on its WR_ACK edge, and during WAIT.
    accept(1'b1, 10'h3FD, 32'h5555AAAA);
    req_valid = 1'b0;
    reset_at(last_t + LAT);
    accept(1'b1, 10'h3FC, 32'hA5A5A5A5);
    req_valid = 1'b0;
    reset_at(last_t + 1);
    do_op(1'b0, 10'h3FC, '0);

    // Random mix inside the initialised windows.
    for (int i = 0; i < 80; i++) begin
      a = AW'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1) a = a | 10'h3E0;
      do_op(1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end

    for (int i = 0; i < 30 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d outstanding exp 0", q.size());
    end
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
